// File: rtl/soc_system_pio_in_edge.sv
// Avalon-MM parallel input port with edge capture and a level interrupt.
// Inputs are double-synchronised, and edge detection is held off until the sync pipeline holds real samples.
`timescale 1ns/1ps

module soc_system_pio_in_edge #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned EDGE_TYPE = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    input  logic [WIDTH-1:0]  in_port,
    output logic [31:0]       readdata,
    output logic              irq
);

    localparam int unsigned ARM_W    = 2;
    localparam int unsigned ARM_DONE = 3;

    logic [WIDTH-1:0] s1_q, s2_q, sprev_q;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [WIDTH-1:0] ec_q, ec_d;
    logic [ARM_W-1:0] arm_cnt_q, arm_cnt_d;
    logic [31:0]      readdata_q, readdata_d;

    logic             wr_en;
    logic             armed;
    logic [WIDTH-1:0] edge_det;
    logic [WIDTH-1:0] clr_bits;

    // Bus decode, edge selection, capture/mask update and read mux
    always_comb begin
        wr_en      = chipselect & ~write_n;
        armed      = (arm_cnt_q == ARM_W'(ARM_DONE));
        arm_cnt_d  = armed ? arm_cnt_q : arm_cnt_q + ARM_W'(1);
        edge_det   = '0;
        clr_bits   = '0;
        mask_d     = mask_q;
        readdata_d = '0;

        case (EDGE_TYPE)
            0:       edge_det = s2_q & ~sprev_q;
            1:       edge_det = ~s2_q & sprev_q;
            default: edge_det = s2_q ^ sprev_q;
        endcase

        if (wr_en && address == 2'd2) begin
            mask_d = writedata[WIDTH-1:0];
        end
        if (wr_en && address == 2'd3) begin
            clr_bits = writedata[WIDTH-1:0];
        end

        // A new edge in the same cycle as its clear keeps the bit set
        ec_d = (ec_q & ~clr_bits) | (armed ? edge_det : '0);

        case (address)
            2'd0:    readdata_d = 32'(s2_q);
            2'd2:    readdata_d = 32'(mask_q);
            2'd3:    readdata_d = 32'(ec_q);
            default: readdata_d = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_q       <= '0;
            s2_q       <= '0;
            sprev_q    <= '0;
            mask_q     <= '0;
            ec_q       <= '0;
            arm_cnt_q  <= '0;
            readdata_q <= '0;
        end else begin
            s1_q       <= in_port;
            s2_q       <= s1_q;
            sprev_q    <= s2_q;
            mask_q     <= mask_d;
            ec_q       <= ec_d;
            arm_cnt_q  <= arm_cnt_d;
            readdata_q <= readdata_d;
        end
    end

    assign readdata = readdata_q;
    assign irq      = |(ec_q & mask_q);

endmodule

// File: tb/tb_soc_system_pio_in_edge.sv
// Bench for soc_system_pio_in_edge: rising, falling and any-edge instances share one bus and input,
// checked each cycle against a sample-history model plus directed literal expectations.
`timescale 1ns/1ps

module tb_soc_system_pio_in_edge;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [1:0]        address = '0;
    logic              chipselect = 1'b0;
    logic              write_n = 1'b1;
    logic [31:0]       writedata = '0;
    logic [31:0]       in_port = '0;
    logic [2:0][31:0]  rd_v;
    logic [2:0]        irq_v;

    int n_checks = 0;
    int n_errors = 0;

    soc_system_pio_in_edge #(.WIDTH(32), .EDGE_TYPE(0)) u_rise (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(rd_v[0]), .irq(irq_v[0]));
    soc_system_pio_in_edge #(.WIDTH(32), .EDGE_TYPE(1)) u_fall (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(rd_v[1]), .irq(irq_v[1]));
    soc_system_pio_in_edge #(.WIDTH(32), .EDGE_TYPE(2)) u_any (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(rd_v[2]), .irq(irq_v[2]));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: keep the last three input samples and count edges since reset.
    // s2 before edge k is the sample from edge k-2, s_prev the one from k-3; captures allowed from the 4th edge.
    logic [31:0] h0, h1, h2;
    int          m_n;
    logic [31:0] m_mask;
    logic [31:0] m_ec [3];
    logic [31:0] m_rd [3];

    function automatic logic [31:0] edges(input int t, input logic [31:0] cur, input logic [31:0] prev);
        if (t == 0) return cur & ~prev;
        if (t == 1) return ~cur & prev;
        return cur ^ prev;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            h0 <= '0; h1 <= '0; h2 <= '0;
            m_n <= 0;
            m_mask <= '0;
            for (int t = 0; t < 3; t++) begin
                m_ec[t] <= '0;
                m_rd[t] <= '0;
            end
        end else begin
            for (int t = 0; t < 3; t++) begin
                case (address)
                    2'd0:    m_rd[t] <= h1;
                    2'd2:    m_rd[t] <= m_mask;
                    2'd3:    m_rd[t] <= m_ec[t];
                    default: m_rd[t] <= '0;
                endcase
                m_ec[t] <= (m_ec[t] & ~((chipselect && !write_n && address == 2'd3) ? writedata : 32'h0))
                         | ((m_n >= 3) ? edges(t, h1, h2) : 32'h0);
            end
            if (chipselect && !write_n && address == 2'd2) m_mask <= writedata;
            h0 <= in_port; h1 <= h0; h2 <= h1;
            m_n <= (m_n < 3) ? m_n + 1 : m_n;
        end
    end

    always @(negedge clk) begin
        for (int t = 0; t < 3; t++) begin
            chk($sformatf("model_rd%0d", t), rd_v[t], m_rd[t]);
            chk($sformatf("model_irq%0d", t), 32'(irq_v[t]), 32'(|(m_ec[t] & m_mask)));
        end
    end

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk); #1;
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        @(negedge clk); #1;
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic rd(input logic [1:0] a);
        @(negedge clk); #1;
        address = a;
        @(posedge clk); #1;
    endtask

    task automatic pulse_reset();
        @(negedge clk); #1; reset = 1'b1;
        @(negedge clk); #1; reset = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        // Input held high through reset release must not capture
        in_port = 32'hFFFF_FFFF;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_rd", rd_v[0], 32'h0);
        chk("reset_irq", 32'(irq_v[0]), 32'h0);
        reset = 1'b0;
        repeat (20) begin
            @(negedge clk);
            chk("hold_high_irq", 32'(irq_v[0]), 32'h0);
        end
        rd(2'd3);
        chk("hold_high_ec_rise", rd_v[0], 32'h0);
        chk("hold_high_ec_any", rd_v[2], 32'h0);
        rd(2'd0);
        chk("data_read", rd_v[0], 32'hFFFF_FFFF);

        // Bit0 rising: capture at N+2, irq right after, cleared by write-1
        in_port = 32'h0;
        pulse_reset();
        wr(2'd2, 32'h1);
        @(negedge clk); #1; in_port = 32'h1;
        repeat (2) @(negedge clk);
        chk("irq_before_n2", 32'(irq_v[0]), 32'h0);
        @(negedge clk);
        chk("irq_after_n2", 32'(irq_v[0]), 32'h1);
        rd(2'd3);
        chk("ec_bit0", rd_v[0], 32'h1);
        rd(2'd2);
        chk("mask_read", rd_v[0], 32'h1);
        rd(2'd1);
        chk("reserved_read", rd_v[0], 32'h0);
        wr(2'd3, 32'h1);
        chk("irq_cleared", 32'(irq_v[0]), 32'h0);

        // Masked capture, then unmask raises irq
        wr(2'd2, 32'h0);
        @(negedge clk); #1; in_port = 32'h21;
        repeat (4) @(negedge clk);
        rd(2'd3);
        chk("ec_bit5", rd_v[0], 32'h20);
        chk("irq_masked", 32'(irq_v[0]), 32'h0);
        wr(2'd2, 32'h20);
        chk("irq_unmasked", 32'(irq_v[0]), 32'h1);

        // Clear coinciding with a new edge: set wins
        wr(2'd3, 32'hFFFF_FFFF);
        wr(2'd2, 32'h0);
        @(negedge clk); #1; in_port = 32'h25;
        @(negedge clk);
        @(negedge clk); #1;
        address = 2'd3; writedata = 32'h4; chipselect = 1'b1; write_n = 1'b0;
        @(negedge clk); #1;
        chipselect = 1'b0; write_n = 1'b1;
        rd(2'd3);
        chk("set_wins_rise", rd_v[0], 32'h4);
        chk("set_wins_fall", rd_v[1], 32'h0);
        chk("set_wins_any", rd_v[2], 32'h4);

        // Bit3 up then down with a clear between
        wr(2'd3, 32'hFFFF_FFFF);
        @(negedge clk); #1; in_port = 32'h2D;
        repeat (4) @(negedge clk);
        rd(2'd3);
        chk("toggle_up_fall", rd_v[1], 32'h0);
        chk("toggle_up_any", rd_v[2], 32'h8);
        wr(2'd3, 32'h8);
        @(negedge clk); #1; in_port = 32'h25;
        repeat (4) @(negedge clk);
        rd(2'd3);
        chk("toggle_down_fall", rd_v[1], 32'h8);
        chk("toggle_down_any", rd_v[2], 32'h8);
        chk("toggle_down_rise", rd_v[0], 32'h0);

        // Pending captures wiped by a mid-cycle reset
        @(negedge clk); #1; in_port = 32'h0;
        repeat (4) @(negedge clk);
        wr(2'd3, 32'hFFFF_FFFF);
        wr(2'd2, 32'hF);
        @(negedge clk); #1; in_port = 32'hF;
        repeat (4) @(negedge clk);
        rd(2'd3);
        chk("pending_ec", rd_v[0], 32'hF);
        chk("pending_irq", 32'(irq_v[0]), 32'h1);
        @(negedge clk); #2; reset = 1'b1;
        #1;
        chk("async_irq", 32'(irq_v[0]), 32'h0);
        chk("async_rd", rd_v[0], 32'h0);
        address = 2'd3;
        repeat (2) @(negedge clk);
        chk("reset_hold_rd", rd_v[0], 32'h0);
        #1; reset = 1'b0;

        // Random traffic against the model
        repeat (3000) begin
            @(negedge clk); #1;
            if ($urandom_range(0, 3) == 0) in_port = in_port ^ (32'h1 << $urandom_range(0, 31));
            if ($urandom_range(0, 15) == 0) in_port = $urandom;
            address    = 2'($urandom_range(0, 3));
            chipselect = ($urandom_range(0, 2) != 0);
            write_n    = ($urandom_range(0, 2) != 0);
            writedata  = $urandom & $urandom;
            reset      = ($urandom_range(0, 299) == 0);
        end
        @(negedge clk); #1;
        reset = 1'b0; chipselect = 1'b0; write_n = 1'b1;
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/soc_system_pio_in_edge.md
SOC_SYSTEM_PIO_IN_EDGE -- requirements
Module: soc_system_pio_in_edge

Interface
REQ-001 Parameter WIDTH, default 32, input port width in bits (1..32).
REQ-002 Parameter EDGE_TYPE, default 0, capture polarity: 0 rising, 1 falling, 2 any edge.
REQ-003 Port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 Port reset  input  1  asynchronous, active-high reset.
REQ-005 Port address  input  2  Avalon-MM slave word address.
REQ-006 Port chipselect  input  1  slave select.
REQ-007 Port write_n  input  1  active-low write strobe.
REQ-008 Port writedata  input  32  write data.
REQ-009 Port in_port  input  WIDTH  asynchronous external inputs.
REQ-010 Port readdata  output  32  registered read data.
REQ-011 Port irq  output  1  level interrupt, active-high.

Function
REQ-012 The block SHALL synchronise in_port through two flip-flop stages (s1, s2) plus a history stage (s_prev = s2 delayed one cycle).
REQ-013 Edge detect per bit SHALL be: rising = s2 & ~s_prev; falling = ~s2 & s_prev; any = s2 ^ s_prev; selected by EDGE_TYPE.
REQ-014 Timing: an in_port transition meeting setup before clk edge N SHALL set the edgecapture bit at edge N+2; irq SHALL be high in the cycle after edge N+2 if the bit is unmasked.
REQ-015 Register map: addr 0 data (RO, zero-extended s2); addr 1 reserved (reads 0, writes ignored); addr 2 irqmask (RW, WIDTH bits); addr 3 edgecapture (R, write-1-to-clear).
REQ-016 A write SHALL occur when chipselect=1 and write_n=0; writes to addr 0 and addr 1 SHALL have no effect.
REQ-017 Write to addr 2 SHALL load irqmask <= writedata[WIDTH-1:0] at that edge.
REQ-018 Write to addr 3 SHALL clear each edgecapture bit where writedata bit = 1; bits written 0 are unchanged.
REQ-019 Simultaneous clear and new edge on the same bit in the same cycle: set SHALL win (bit remains 1).
REQ-020 edgecapture bits SHALL be sticky: once set, hold until cleared by REQ-018 or reset.
REQ-021 readdata SHALL be registered every clk edge from the address-selected mux, independent of chipselect; read latency fixed at 1 cycle; bits above WIDTH SHALL read 0.
REQ-022 irq SHALL equal OR-reduction of (edgecapture & irqmask), derived only from registers (no combinational path from bus inputs).
REQ-023 After reset release, edge detection SHALL be disarmed for 3 cycles (until s1, s2, s_prev hold real samples); no edgecapture bit may set during that window.

Reset
REQ-024 While reset=1: s1, s2, s_prev, irqmask, edgecapture, readdata SHALL be 0, irq SHALL be 0, arm counter SHALL be 0.
REQ-025 Reset assertion mid-operation SHALL clear all state immediately (asynchronous), discarding pending edges and masks.
REQ-026 An input held at 1 through reset release SHALL NOT produce a rising capture (guaranteed by REQ-023).

Verification
REQ-027 Reset release with in_port=0xFFFFFFFF, EDGE_TYPE=0 -> edgecapture stays 0x0, irq stays 0 for 20 cycles; read addr 0 returns 0xFFFFFFFF.
REQ-028 EDGE_TYPE=0, irqmask=0x1, in_port bit0 0->1 before edge N -> read addr 3 returns 0x1 from edge N+2; irq=1 after edge N+2; write 0x1 to addr 3 -> irq=0 next cycle.
REQ-029 irqmask=0x0, bit5 rising edge -> edgecapture=0x20, irq=0; then write 0x20 to addr 2 -> irq=1 next cycle.
REQ-030 Clear write of 0x4 to addr 3 in the same cycle bit2 edge is detected -> edgecapture bit2 remains 1.
REQ-031 EDGE_TYPE=2, bit3 toggles 0->1->0 with one capture cleared between -> two separate captures; EDGE_TYPE=1 same stimulus -> only 1->0 captured.
REQ-032 Pending edgecapture=0xF, irqmask=0xF, assert reset mid-cycle -> irq and all registers 0 asynchronously; readdata 0 while reset=1.
